// File: rtl/sipo_sched_pkg.sv
// Shared types and width helpers for the multi-requester SIPO packer.
// Module-parameter-dependent sizes are derived through these functions.
package sipo_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_EMIT    = 2'd2
    } state_t;

    // Index width for n items; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int num_shifts(input int out_w, input int in_w);
        return out_w / in_w;
    endfunction

endpackage

// File: rtl/sipo_sched_rr_arbiter.sv
// Round-robin selector: picks the lowest-index request at or after the
// pointer, wrapping around, and returns it both one-hot and as an index.
module rr_arbiter
    import sipo_sched_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = idx_width(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  gnt_o,
    output logic [IW-1:0] gnt_idx_o,
    output logic          gnt_vld_o
);

    always_comb begin
        int j;
        gnt_o     = '0;
        gnt_idx_o = '0;
        gnt_vld_o = 1'b0;
        j         = 0;
        for (int i = 0; i < N; i++) begin
            j = int'(ptr_i) + i;
            if (j >= N) begin
                j = j - N;
            end
            if (!gnt_vld_o && req_i[j]) begin
                gnt_vld_o = 1'b1;
                gnt_idx_o = IW'(j);
                gnt_o[j]  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sipo_sched.sv
// Packs narrow beats from several requesters into wide words, one word per
// grant, with a per-requester auto-incrementing destination address.
module sipo_sched
    import sipo_sched_pkg::*;
#(
    parameter int NUM_REQ        = 4,
    parameter int DATA_IN_WIDTH  = 16,
    parameter int DATA_OUT_WIDTH = 64,
    parameter int ADDR_WIDTH     = 10
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               cfg_load,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]      cfg_base,
    input  logic [NUM_REQ-1:0]                 req_vld,
    input  logic [NUM_REQ*DATA_IN_WIDTH-1:0]   req_dat,
    input  logic [NUM_REQ-1:0]                 req_last,
    output logic [NUM_REQ-1:0]                 req_rdy,
    output logic                               wr_vld,
    input  logic                               wr_rdy,
    output logic [DATA_OUT_WIDTH-1:0]          wr_dat,
    output logic [ADDR_WIDTH-1:0]              wr_addr,
    output logic [idx_width(NUM_REQ)-1:0]      wr_id,
    output logic                               busy
);

    localparam int NS = num_shifts(DATA_OUT_WIDTH, DATA_IN_WIDTH);
    localparam int IW = idx_width(NUM_REQ);
    localparam int BW = idx_width(NS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
    localparam logic [IW-1:0]         IDX_ONE  = 1;
    localparam logic [BW-1:0]         BEAT_ONE = 1;

    state_t                    state_q, state_d;
    logic [IW-1:0]             grant_q, grant_d;
    logic [IW-1:0]             ptr_q, ptr_d;
    logic [BW-1:0]             beat_cnt_q, beat_cnt_d;
    logic [DATA_IN_WIDTH-1:0]  lanes_q [NS];
    logic [DATA_IN_WIDTH-1:0]  lanes_d [NS];
    logic [ADDR_WIDTH-1:0]     addr_q [NUM_REQ];
    logic [ADDR_WIDTH-1:0]     addr_d [NUM_REQ];
    logic [ADDR_WIDTH-1:0]     wr_addr_q, wr_addr_d;

    logic [ADDR_WIDTH-1:0]     base_w [NUM_REQ];
    logic [DATA_IN_WIDTH-1:0]  dat_w [NUM_REQ];
    logic [NUM_REQ-1:0]        arb_gnt;
    logic [IW-1:0]             arb_idx;
    logic                      arb_vld;
    logic [ADDR_WIDTH-1:0]     addr_sel;
    logic                      accept;

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_arb (
        .req_i     (req_vld),
        .ptr_i     (ptr_q),
        .gnt_o     (arb_gnt),
        .gnt_idx_o (arb_idx),
        .gnt_vld_o (arb_vld)
    );

    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
        assign base_w[gi]  = cfg_base[gi*ADDR_WIDTH +: ADDR_WIDTH];
        assign dat_w[gi]   = req_dat[gi*DATA_IN_WIDTH +: DATA_IN_WIDTH];
        assign req_rdy[gi] = (state_q == ST_COLLECT) && (grant_q == IW'(gi));
    end

    for (genvar gi = 0; gi < NS; gi++) begin : g_lane
        assign wr_dat[gi*DATA_IN_WIDTH +: DATA_IN_WIDTH] = lanes_q[gi];
    end

    assign wr_vld  = (state_q == ST_EMIT);
    assign busy    = (state_q != ST_IDLE);
    assign wr_addr = wr_addr_q;
    assign wr_id   = grant_q;
    assign accept  = (state_q == ST_COLLECT) && req_vld[grant_q];

    // One-hot grant selects the winner's current address to latch for the word.
    always_comb begin
        addr_sel = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (arb_gnt[k]) begin
                addr_sel = addr_sel | addr_q[k];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        lanes_d    = lanes_q;
        addr_d     = addr_q;
        wr_addr_d  = wr_addr_q;
        case (state_q)
            ST_IDLE: begin
                if (arb_vld) begin
                    grant_d   = arb_idx;
                    wr_addr_d = addr_sel;
                    state_d   = ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (accept) begin
                    lanes_d[beat_cnt_q] = dat_w[grant_q];
                    beat_cnt_d          = beat_cnt_q + BEAT_ONE;
                    if (beat_cnt_q == BW'(NS - 1) || req_last[grant_q]) begin
                        state_d = ST_EMIT;
                    end
                end
            end
            ST_EMIT: begin
                if (wr_rdy) begin
                    addr_d[grant_q] = addr_q[grant_q] + ADDR_ONE;
                    ptr_d      = (grant_q == IW'(NUM_REQ - 1)) ? '0 : grant_q + IDX_ONE;
                    beat_cnt_d = '0;
                    lanes_d    = '{default: '0};
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // A reload overrides any increment; the latched word address is untouched.
        if (cfg_load) begin
            for (int k = 0; k < NUM_REQ; k++) begin
                addr_d[k] = base_w[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
            lanes_q    <= '{default: '0};
            addr_q     <= '{default: '0};
            wr_addr_q  <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
            lanes_q    <= lanes_d;
            addr_q     <= addr_d;
            wr_addr_q  <= wr_addr_d;
        end
    end

endmodule
